// File: rtl/posit_unit_arbiter.sv
// Two-requester front end for a shared combinational posit unit.
// Round-robin grant, registered operands, fixed settle time, held response.
module posit_unit_arbiter #(
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [DATA_W-1:0]   pu_in_1,
  output logic [DATA_W-1:0]   pu_in_2,
  input  logic [DATA_W-1:0]   pu_res,
  output logic                busy,
  output logic [7:0]          op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic       prio;
  logic       owner;
  logic [3:0] cnt;
  logic       g_idx;
  logic       any_valid;
  logic [1:0] grant;
  logic       accept;
  logic       exec_done;
  logic       rsp_done;

  // Favoured requester wins; otherwise fall back to whichever one is valid.
  always_comb begin
    any_valid = |req_valid;
    g_idx     = prio;
    if (!req_valid[prio] && req_valid[~prio]) begin
      g_idx = ~prio;
    end
    grant = any_valid ? (2'b01 << g_idx) : 2'b00;
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign exec_done = (state == EXEC) && (cnt == 4'd0);
  assign rsp_done  = (state == RESP) && rsp_ready[owner];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      cnt       <= 4'd0;
      pu_in_1   <= '0;
      pu_in_2   <= '0;
      rsp_data  <= '0;
      rsp_valid <= 2'b00;
      op_count  <= 8'd0;
    end else begin
      if (accept) begin
        pu_in_1 <= g_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        pu_in_2 <= g_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        owner   <= g_idx;
        cnt     <= 4'(LAT - 1);
      end else if ((state == EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (exec_done) begin
        rsp_data  <= pu_res;
        rsp_valid <= 2'b01 << owner;
      end
      // Handing priority to the other side keeps contention fair.
      if (rsp_done) begin
        rsp_valid <= 2'b00;
        prio      <= ~owner;
        op_count  <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_posit_unit_arbiter.sv
// Directed bench for posit_unit_arbiter with an adder stub as the posit unit.
module tb_posit_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] rsp_data, pu_in_1, pu_in_2, pu_res;
  logic        busy;
  logic [7:0]  op_count;

  logic [1:0]  aux_valid;
  logic [1:0]  l1_req_ready, l1_rsp_valid, l15_req_ready, l15_rsp_valid;
  logic [15:0] l1_rsp_data, l1_in_1, l1_in_2, l1_res;
  logic [15:0] l15_rsp_data, l15_in_1, l15_in_2, l15_res;
  logic        l1_busy, l15_busy;
  logic [7:0]  l1_op_count, l15_op_count;

  int   total = 0;
  int   bad = 0;
  int   exp_ops = 0;
  logic exp_prio = 1'b0;

  typedef struct {
    int unsigned r;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign pu_res  = pu_in_1 + pu_in_2;
  assign l1_res  = l1_in_1 + l1_in_2;
  assign l15_res = l15_in_1 + l15_in_2;

  posit_unit_arbiter #(.DATA_W(16), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .pu_in_1(pu_in_1), .pu_in_2(pu_in_2), .pu_res(pu_res),
    .busy(busy), .op_count(op_count)
  );

  posit_unit_arbiter #(.DATA_W(16), .LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(aux_valid), .req_ready(l1_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(l1_rsp_valid), .rsp_ready(2'b11),
    .rsp_data(l1_rsp_data), .pu_in_1(l1_in_1), .pu_in_2(l1_in_2), .pu_res(l1_res),
    .busy(l1_busy), .op_count(l1_op_count)
  );

  posit_unit_arbiter #(.DATA_W(16), .LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(aux_valid), .req_ready(l15_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(l15_rsp_valid), .rsp_ready(2'b11),
    .rsp_data(l15_rsp_data), .pu_in_1(l15_in_1), .pu_in_2(l15_in_2), .pu_res(l15_res),
    .busy(l15_busy), .op_count(l15_op_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One complete operation from a single requester with rsp_ready held high.
  task automatic applyStimulus(input int r, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] res);
    int lat;
    logic [1:0] onehot;
    onehot = (r == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    rsp_ready = 2'b11;
    if (r == 0) begin
      req_a[15:0] = a;
      req_b[15:0] = b;
    end else begin
      req_a[31:16] = a;
      req_b[31:16] = b;
    end
    req_valid = onehot;
    #1 checkOutput("vec_req_ready", req_ready, onehot);
    @(posedge clk);
    #1 req_valid = 2'b00;
    lat = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && lat < 40) begin
      checkOutput("vec_pu_in_1", pu_in_1, a);
      checkOutput("vec_pu_in_2", pu_in_2, b);
      @(negedge clk);
      lat++;
    end
    checkOutput("vec_latency", lat, 2);
    checkOutput("vec_rsp_valid", rsp_valid, onehot);
    checkOutput("vec_rsp_data", rsp_data, res);
    checkOutput("vec_busy_resp", busy, 1);
    @(negedge clk);
    exp_ops++;
    exp_prio = (r == 0);
    checkOutput("vec_rsp_valid_drop", rsp_valid, 0);
    checkOutput("vec_busy_after", busy, 0);
    checkOutput("vec_op_count", op_count, exp_ops % 256);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lim;
    int lat1, lat15;
    int remaining;
    logic seen;

    vecs[0] = '{0, 16'h4000, 16'h1000, 16'h5000};
    vecs[1] = '{1, 16'h1234, 16'h0001, 16'h1235};
    vecs[2] = '{0, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[3] = '{1, 16'h8000, 16'h8000, 16'h0000};
    vecs[4] = '{0, 16'h7FFF, 16'h0001, 16'h8000};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    aux_valid = 2'b00;
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_pu_in_1", pu_in_1, 0);
    checkOutput("rst_pu_in_2", pu_in_2, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(int'(vecs[i].r), vecs[i].a, vecs[i].b, vecs[i].res);
    end

    // LAT=1 and LAT=15 instances: latency and operand stability.
    @(negedge clk);
    req_a[15:0] = 16'h0300;
    req_b[15:0] = 16'h0041;
    aux_valid   = 2'b01;
    #1;
    checkOutput("l1_req_ready", l1_req_ready, 2'b01);
    checkOutput("l15_req_ready", l15_req_ready, 2'b01);
    @(posedge clk);
    #1 aux_valid = 2'b00;
    req_a[15:0] = 16'hDEAD;
    req_b[15:0] = 16'hBEEF;
    lat1  = 0;
    lat15 = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (l1_rsp_valid[0] && lat1 == 0) lat1 = k;
      if (l15_rsp_valid[0] && lat15 == 0) lat15 = k;
      if (k == 8) begin
        checkOutput("l15_pu_in_1", l15_in_1, 16'h0300);
        checkOutput("l15_pu_in_2", l15_in_2, 16'h0041);
        checkOutput("l15_busy", l15_busy, 1);
      end
    end
    checkOutput("l1_latency", lat1, 1);
    checkOutput("l15_latency", lat15, 15);
    checkOutput("l1_rsp_data", l1_rsp_data, 16'h0341);
    checkOutput("l15_rsp_data", l15_rsp_data, 16'h0341);
    checkOutput("l1_op_count", l1_op_count, 1);
    checkOutput("l15_op_count", l15_op_count, 1);
    checkOutput("l1_busy", l1_busy, 0);

    // Contention: both valid, grants alternate starting from the favoured side.
    @(negedge clk);
    req_a     = {16'h0010, 16'h0001};
    req_b     = {16'h0020, 16'h0002};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      lim = 0;
      while (req_ready == 2'b00 && lim < 20) begin
        @(negedge clk);
        lim++;
      end
      checkOutput("rr_grant", req_ready, exp_prio ? 2'b10 : 2'b01);
      lim = 0;
      while (rsp_valid == 2'b00 && lim < 20) begin
        @(negedge clk);
        lim++;
      end
      checkOutput("rr_rsp_valid", rsp_valid, exp_prio ? 2'b10 : 2'b01);
      checkOutput("rr_rsp_data", rsp_data, exp_prio ? 16'h0030 : 16'h0003);
      if (k == 3) req_valid = 2'b00;
      exp_prio = ~exp_prio;
      exp_ops++;
    end
    @(negedge clk);
    checkOutput("rr_op_count", op_count, exp_ops % 256);

    // Backpressure on requester 0 while requester 1 waits.
    req_a[15:0] = 16'h0A00;
    req_b[15:0] = 16'h00B0;
    rsp_ready   = 2'b10;
    req_valid   = 2'b01;
    #1 checkOutput("bp_req_ready0", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b10;
    req_a[31:16] = 16'h0007;
    req_b[31:16] = 16'h0008;
    lim = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid_hold", rsp_valid, 2'b01);
      checkOutput("bp_rsp_data_hold", rsp_data, 16'h0AB0);
      checkOutput("bp_req_ready1_blocked", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    #1 checkOutput("bp_req_ready1_pre", req_ready, 2'b00);
    @(negedge clk);
    exp_ops++;
    checkOutput("bp_rsp_valid_drop", rsp_valid, 2'b00);
    checkOutput("bp_req_ready1_grant", req_ready, 2'b10);
    lim = 0;
    while (rsp_valid == 2'b00 && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    req_valid = 2'b00;
    checkOutput("bp_rsp_valid1", rsp_valid, 2'b10);
    checkOutput("bp_rsp_data1", rsp_data, 16'h000F);
    @(negedge clk);
    exp_ops++;
    exp_prio = 1'b0;
    checkOutput("bp_op_count", op_count, exp_ops % 256);

    // Run requester 0 alone until the completed-operation counter wraps.
    remaining = 256 - exp_ops;
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    #1;
    for (int i = 0; i < remaining; i++) begin
      lim = 0;
      while (rsp_valid[0] == 1'b0 && lim < 20) begin
        @(negedge clk);
        lim++;
      end
      if (i == remaining - 1) begin
        checkOutput("wrap_op_count_255", op_count, 255);
        req_valid = 2'b00;
      end
      @(negedge clk);
      exp_ops++;
    end
    checkOutput("wrap_op_count_0", op_count, exp_ops % 256);
    checkOutput("wrap_busy", busy, 0);

    // Reset in the middle of EXEC.
    @(negedge clk);
    req_a[15:0] = 16'h0100;
    req_b[15:0] = 16'h0200;
    req_valid   = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_rsp_valid", rsp_valid, 0);
    checkOutput("mid_pu_in_1", pu_in_1, 0);
    checkOutput("mid_pu_in_2", pu_in_2, 0);
    checkOutput("mid_rsp_data", rsp_data, 0);
    checkOutput("mid_op_count", op_count, 0);
    checkOutput("mid_req_ready", req_ready, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    checkOutput("mid_no_rsp_pulse", seen, 0);
    exp_ops  = 0;
    exp_prio = 1'b0;
    applyStimulus(0, 16'h1111, 16'h2222, 16'h3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_unit_arbiter.md
# posit_unit_arbiter

Sequences and shares one combinational posit unit (16-bit operands, 16-bit result) between two requesters. Each requester has its own valid/ready request channel and valid/ready response channel. Operands are held in registers for a fixed settle time, then the result is captured and returned to the requester that issued it. Only one operation is in flight at a time. The block sits between host-side front ends (byte-serial loaders) and the posit datapath instance.

## Interface
- DATA_W, 16, operand/result width; must match the posit unit.
- LAT, 2, settle cycles between operand registration and result capture; legal range 1..15.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accept.
- req_a  in  2*DATA_W  operand 1; requester i in bits [i*DATA_W +: DATA_W].
- req_b  in  2*DATA_W  operand 2; same packing as req_a.
- rsp_valid  out  2  per-requester response valid; at most one bit high.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  result; shared by both requesters; qualified by rsp_valid.
- pu_in_1  out  DATA_W  registered operand 1 to the posit unit.
- pu_in_2  out  DATA_W  registered operand 2 to the posit unit.
- pu_res  in  DATA_W  posit unit result; combinational function of pu_in_1/2.
- busy  out  1  high in EXEC or RESP.
- op_count  out  8  completed operations; wraps 255 -> 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant is combinational round-robin over req_valid; priority pointer prio selects the favoured requester.
  - req_ready[i] = IDLE && grant[i]. req_ready is one-hot or zero.
  - Accept = req_valid[g] && req_ready[g].
  - On accept:
    - pu_in_1 <= req_a slice of g; pu_in_2 <= req_b slice of g.
    - owner <= g; cnt <= LAT-1; go to EXEC.
  - With no valid request, stay in IDLE; all registers hold.
- **EXEC:**
  - If cnt == 0: rsp_data <= pu_res; rsp_valid[owner] <= 1; go to RESP.
  - Otherwise cnt <= cnt-1.
  - req_valid is ignored; req_ready = 0.
- **RESP:**
  - Hold rsp_valid[owner] and rsp_data until rsp_ready[owner] = 1 at a clock edge.
  - On that edge:
    - rsp_valid <= 0.
    - prio <= ~owner, so the other requester is favoured next.
    - op_count <= op_count+1.
    - Go to IDLE.
  - rsp_ready of the non-owner is ignored.
- pu_in_1/pu_in_2 keep their last operands after completion; they change only on accept.
- A requester may drop req_valid before it is granted; no state is affected.
- Reset values: state IDLE, prio 0 (requester 0 favoured), owner 0, cnt 0, pu_in_1/pu_in_2 0, rsp_data 0, rsp_valid 0, req_ready combinationally 0 unless req_valid is high, busy 0, op_count 0.
- Reset asserted mid-operation aborts the operation. No response is issued and all registers return to their reset values immediately.

## Timing
- Accept edge E0 → result captured at edge E(LAT) → rsp_valid high after E(LAT). Latency is LAT cycles.
- Earliest next accept is the edge after the rsp handshake edge. Minimum period is LAT+2 cycles per operation at full rsp_ready.
- rsp_ready already high when rsp_valid rises: the handshake completes on the first edge rsp_valid is high, so rsp_valid is high for exactly 1 cycle.
- Simultaneous req_valid = 2'b11 in IDLE: requester prio is granted. The other requester is granted on its next IDLE visit if it is still valid.
- Single requester with continuous valid: it is granted every IDLE visit. prio toggling does not block it, because grant falls back to any valid requester.
- busy is registered state (EXEC|RESP). It falls on the same edge the FSM enters IDLE.

## Test plan
The bench binds pu_res = pu_in_1 + pu_in_2 (mod 2^16) as a stub; LAT = 2 unless stated.
- **Single request, rsp_ready held high:** reset, then requester 0 sends a=0x4000, b=0x1000 → req_ready[0] high in IDLE; rsp_valid[0] high exactly 2 cycles after accept; rsp_data=0x5000; op_count=1; busy low afterwards.
- **Contention and round-robin:** both requesters continuously valid, a0=0x0001/b0=0x0002, a1=0x0010/b1=0x0020, rsp_ready=2'b11 → grants alternate 0,1,0,1; responses alternate 0x0003 (rsp_valid[0]) and 0x0030 (rsp_valid[1]); never both rsp_valid bits high.
- **Response backpressure:** rsp_ready[0]=0 for 5 cycles after rsp_valid[0] rises, and requester 1 is valid meanwhile → rsp_valid[0]/rsp_data stable for all 5 cycles; req_ready[1]=0 until the cycle after the handshake; requester 1 is then granted.
- **Wrap-around:** a=0xFFFF, b=0x0002 → rsp_data=0x0001. Separately, 256 completed operations → op_count returns to 0.
- **Reset mid-operation:** assert rst_n=0 during EXEC (cycle 1 after accept) → no rsp_valid pulse; all outputs at reset values while low; after release a new request completes normally with LAT-cycle latency.
- **Settle-time parameter:** LAT=1 and LAT=15 builds → rsp_valid rises exactly 1 and 15 cycles after accept respectively; pu_in_1/pu_in_2 stable throughout EXEC.
